// File: rtl/sm4_round_key_store.sv
// Round-key store for an SM4 core: loads a full key schedule once, then streams it
// forward (encrypt) or reversed (decrypt) any number of times under a valid/yumi handshake.
module sm4_round_key_store #(
  parameter int width_p  = 32,
  parameter int rounds_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        rk_v_i,
  input  logic [width_p-1:0]          rk_i,
  output logic                        rk_ready_o,
  input  logic                        start_i,
  input  logic                        decrypt_i,
  input  logic                        clear_i,
  output logic                        v_o,
  output logic [width_p-1:0]          rk_o,
  output logic [$clog2(rounds_p)-1:0] round_o,
  input  logic                        yumi_i,
  output logic                        loaded_o,
  output logic                        done_o
);

  localparam int cnt_w = $clog2(rounds_p);
  localparam logic [cnt_w-1:0] last_c = cnt_w'(rounds_p - 1);
  localparam logic [cnt_w-1:0] one_c  = cnt_w'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_READY,
    S_STREAM
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [width_p-1:0] r_mem [rounds_p];
  logic [cnt_w-1:0]   r_wcnt;
  logic [cnt_w-1:0]   r_rptr;
  logic [cnt_w-1:0]   r_round;
  logic               r_decrypt;
  logic               r_done;

  logic w_wr;
  logic w_start;
  logic w_take;
  logic w_last;
  logic w_load_full;

  // Handshakes only count in the state that honours them; clear_i masks everything.
  assign w_wr        = (r_state == S_LOAD) && rk_v_i && !clear_i;
  assign w_start     = (r_state == S_READY) && start_i && !clear_i;
  assign w_take      = (r_state == S_STREAM) && yumi_i && !clear_i;
  assign w_last      = w_take && (r_round == last_c);
  assign w_load_full = w_wr && (r_wcnt == last_c);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    rk_ready_o   = 1'b0;
    loaded_o     = 1'b0;
    v_o          = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        rk_ready_o = 1'b1;
        if (w_load_full) w_state_next = S_READY;
      end
      S_READY: begin
        loaded_o = 1'b1;
        if (w_start) w_state_next = S_STREAM;
      end
      S_STREAM: begin
        v_o = 1'b1;
        if (w_last) w_state_next = S_READY;
      end
      default: w_state_next = S_LOAD;
    endcase
    if (clear_i) w_state_next = S_LOAD;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < rounds_p; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wcnt] <= rk_i;
    end
  end

  // Counters are power-of-two wide, so the last write and last yumi wrap them to 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wcnt    <= '0;
      r_rptr    <= '0;
      r_round   <= '0;
      r_decrypt <= 1'b0;
      r_done    <= 1'b0;
    end else if (clear_i) begin
      r_wcnt    <= '0;
      r_rptr    <= '0;
      r_round   <= '0;
      r_decrypt <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_wr) r_wcnt <= r_wcnt + one_c;
      if (w_start) begin
        r_decrypt <= decrypt_i;
        r_rptr    <= decrypt_i ? last_c : '0;
        r_round   <= '0;
      end else if (w_take) begin
        r_rptr  <= r_decrypt ? (r_rptr - one_c) : (r_rptr + one_c);
        r_round <= r_round + one_c;
      end
    end
  end

  assign rk_o    = v_o ? r_mem[r_rptr] : '0;
  assign round_o = v_o ? r_round : '0;
  assign done_o  = r_done;

endmodule

// File: tb/tb_sm4_round_key_store.sv
// Directed bench for sm4_round_key_store: table of streaming passes plus hand-written
// clear and asynchronous-reset sequences.
module tb_sm4_round_key_store;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rk_v = 1'b0;
  logic [31:0] rk = '0;
  logic        rk_ready;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic        clear = 1'b0;
  logic        v;
  logic [31:0] rk_o;
  logic [4:0]  round;
  logic        yumi = 1'b0;
  logic        loaded;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sm4_round_key_store #(.width_p(32), .rounds_p(32)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .rk_v_i     (rk_v),
    .rk_i       (rk),
    .rk_ready_o (rk_ready),
    .start_i    (start),
    .decrypt_i  (decrypt),
    .clear_i    (clear),
    .v_o        (v),
    .rk_o       (rk_o),
    .round_o    (round),
    .yumi_i     (yumi),
    .loaded_o   (loaded),
    .done_o     (done)
  );

  typedef struct {
    logic        dec;
    int          maxgap;
    logic        chain;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } pass_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All stimulus changes and output samples happen 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_ready"},  64'(rk_ready), 64'd1);
    chk({tag, "_loaded"}, 64'(loaded),   64'd0);
    chk({tag, "_v"},      64'(v),        64'd0);
    chk({tag, "_done"},   64'(done),     64'd0);
    chk({tag, "_rk"},     64'(rk_o),     64'd0);
    chk({tag, "_round"},  64'(round),    64'd0);
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rk_v = 1'b1;
      rk   = base + 32'(i);
      chk("load_ready", 64'(rk_ready), 64'd1);
      chk("load_loaded", 64'(loaded), 64'd0);
      step();
    end
    rk_v = 1'b0;
    rk   = '0;
    if (n == 32) begin
      chk("load_ready_fall", 64'(rk_ready), 64'd0);
      chk("load_loaded_set", 64'(loaded), 64'd1);
    end
    $display("load base=%08h n=%0d", base, n);
  endtask

  task automatic run_pass(input logic dec, input logic [31:0] base, input logic [31:0] first,
                          input logic [31:0] last, input int maxgap, input logic chain);
    logic [31:0] exp_rk;
    int n;
    chk("pre_loaded", 64'(loaded), 64'd1);
    start   = 1'b1;
    decrypt = dec;
    step();
    start   = 1'b0;
    decrypt = ~dec;
    for (int r = 0; r < 32; r++) begin
      exp_rk = dec ? base + 32'(31 - r) : base + 32'(r);
      if (r == 0)  chk("pass_first", 64'(rk_o), 64'(first));
      if (r == 31) chk("pass_last",  64'(rk_o), 64'(last));
      n = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      yumi = 1'b0;
      for (int s = 0; s < n; s++) begin
        start = 1'b1;
        chk("stall_v",     64'(v),     64'd1);
        chk("stall_rk",    64'(rk_o),  64'(exp_rk));
        chk("stall_round", 64'(round), 64'(r));
        step();
      end
      start = 1'b0;
      yumi  = 1'b1;
      chk("pass_v",     64'(v),     64'd1);
      chk("pass_rk",    64'(rk_o),  64'(exp_rk));
      chk("pass_round", 64'(round), 64'(r));
      chk("pass_done",  64'(done),  64'd0);
      step();
      yumi = 1'b0;
    end
    chk("end_done",   64'(done),     64'd1);
    chk("end_v",      64'(v),        64'd0);
    chk("end_rk",     64'(rk_o),     64'd0);
    chk("end_loaded", 64'(loaded),   64'd1);
    chk("end_ready",  64'(rk_ready), 64'd0);
    if (!chain) begin
      step();
      chk("done_pulse_width", 64'(done), 64'd0);
      chk("post_v", 64'(v), 64'd0);
    end
    $display("pass dec=%0d base=%08h gap<=%0d chain=%0d", dec, base, maxgap, chain);
  endtask

  initial begin
    pass_t passes [4];
    passes[0] = '{dec: 1'b0, maxgap: 0, chain: 1'b0, exp_first: 32'h10000000, exp_last: 32'h1000001F};
    passes[1] = '{dec: 1'b1, maxgap: 3, chain: 1'b0, exp_first: 32'h1000001F, exp_last: 32'h10000000};
    passes[2] = '{dec: 1'b1, maxgap: 2, chain: 1'b1, exp_first: 32'h1000001F, exp_last: 32'h10000000};
    passes[3] = '{dec: 1'b0, maxgap: 0, chain: 1'b0, exp_first: 32'h10000000, exp_last: 32'h1000001F};

    #2;
    check_idle_reset("reset0");
    #1 reset = 1'b0;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_load_v", 64'(v), 64'd0);
    chk("start_in_load_ready", 64'(rk_ready), 64'd1);

    load(32'h10000000, 32);

    rk_v = 1'b1;
    rk   = 32'hDEADBEEF;
    step();
    rk_v = 1'b0;
    chk("write_in_ready_ignored", 64'(loaded), 64'd1);

    for (int p = 0; p < 4; p++) begin
      run_pass(passes[p].dec, 32'h10000000, passes[p].exp_first, passes[p].exp_last,
               passes[p].maxgap, passes[p].chain);
    end

    // Clear mid-pass, colliding with yumi, start and a write.
    start   = 1'b1;
    decrypt = 1'b0;
    step();
    start = 1'b0;
    yumi  = 1'b1;
    repeat (5) step();
    chk("pre_clear_round", 64'(round), 64'd5);
    chk("pre_clear_rk", 64'(rk_o), 64'h10000005);
    clear = 1'b1;
    start = 1'b1;
    rk_v  = 1'b1;
    rk    = 32'hBADC0DE0;
    step();
    clear = 1'b0;
    start = 1'b0;
    rk_v  = 1'b0;
    yumi  = 1'b0;
    check_idle_reset("clear");
    step();
    chk("clear_no_done", 64'(done), 64'd0);
    $display("clear mid-pass at round 5");

    load(32'h30000000, 7);
    clear = 1'b1;
    step();
    clear = 1'b0;
    load(32'h20000000, 32);
    run_pass(1'b0, 32'h20000000, 32'h20000000, 32'h2000001F, 1, 1'b0);

    // Asynchronous reset mid-load, then mid-pass.
    clear = 1'b1;
    step();
    clear = 1'b0;
    load(32'h40000000, 10);
    rk_v = 1'b1;
    rk   = 32'h4000000A;
    #2 reset = 1'b1;
    #1;
    check_idle_reset("reset_load");
    rk_v = 1'b0;
    step();
    #2 reset = 1'b0;
    step();
    load(32'h10000000, 32);
    start   = 1'b1;
    decrypt = 1'b0;
    step();
    start = 1'b0;
    yumi  = 1'b1;
    repeat (12) step();
    chk("pre_reset_round", 64'(round), 64'd12);
    #2 reset = 1'b1;
    #1;
    check_idle_reset("reset_pass");
    step();
    chk("reset_hold_v", 64'(v), 64'd0);
    #2 reset = 1'b0;
    yumi = 1'b0;
    step();
    check_idle_reset("post_reset");
    $display("async reset mid-load and mid-pass");

    load(32'h50000000, 32);
    run_pass(1'b1, 32'h50000000, 32'h5000001F, 32'h50000000, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
